vmicro16_alu_branch_unit: RTL and testbench



---
 rtl/vmicro16_alu_branch_unit.sv | 102 ++++++++++
 tb/tb_vmicro16_alu_branch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_alu_branch_unit.sv
// Execute-stage block for vmicro16: combinational 16-bit ALU, CMP-loaded {N,Z,C,V}
// flags register and the branch-condition evaluator that drives PC select.
module vmicro16_alu_branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  input  logic [7:0]  cond,
  output logic [3:0]  flags,
  output logic        en
);

  localparam int DATA_W = 16;

  localparam logic [4:0] OP_MOV  = 5'h04;
  localparam logic [4:0] OP_MOVI = 5'h05;
  localparam logic [4:0] OP_ADD  = 5'h06;
  localparam logic [4:0] OP_SUB  = 5'h07;
  localparam logic [4:0] OP_AND  = 5'h08;
  localparam logic [4:0] OP_OR   = 5'h09;
  localparam logic [4:0] OP_XOR  = 5'h0A;
  localparam logic [4:0] OP_NOT  = 5'h0B;
  localparam logic [4:0] OP_LSL  = 5'h0C;
  localparam logic [4:0] OP_LSR  = 5'h0D;
  localparam logic [4:0] OP_ASR  = 5'h0E;
  localparam logic [4:0] OP_CMP  = 5'h19;

  localparam logic [7:0] BR_U  = 8'h00;
  localparam logic [7:0] BR_E  = 8'h01;
  localparam logic [7:0] BR_NE = 8'h02;
  localparam logic [7:0] BR_G  = 8'h03;
  localparam logic [7:0] BR_GE = 8'h04;
  localparam logic [7:0] BR_L  = 8'h05;
  localparam logic [7:0] BR_LE = 8'h06;
  localparam logic [7:0] BR_S  = 8'h07;
  localparam logic [7:0] BR_NS = 8'h08;

  logic signed [DATA_W-1:0] a_s;
  logic        [DATA_W-1:0] diff;
  logic        [DATA_W:0]   sum_ext;
  logic                     flag_n, flag_z, flag_c, flag_v;

  assign a_s     = a;
  assign diff    = a - b;
  assign sum_ext = {1'b0, a} + {1'b0, b};

  // The carry flag deliberately comes from a+b, not from the subtraction.
  assign flag_n = diff[DATA_W-1];
  assign flag_z = (diff == '0);
  assign flag_c = sum_ext[DATA_W];
  assign flag_v = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    c = '0;
    case (op)
      OP_MOV, OP_MOVI: c = b;
      OP_ADD:          c = sum_ext[DATA_W-1:0];
      OP_SUB:          c = diff;
      OP_AND:          c = a & b;
      OP_OR:           c = a | b;
      OP_XOR:          c = a ^ b;
      OP_NOT:          c = ~a;
      OP_LSL:          c = a << b[3:0];
      OP_LSR:          c = a >> b[3:0];
      OP_ASR:          c = a_s >>> b[3:0];
      OP_CMP:          c = {12'h000, flag_n, flag_z, flag_c, flag_v};
      default:         c = '0;
    endcase
  end

  // Flags register stage: loaded only by CMP, reset has priority.
  always_ff @(posedge clk) begin
    if (reset)
      flags <= 4'b0000;
    else if (op == OP_CMP)
      flags <= c[3:0];
  end

  logic f_n, f_z, f_v;
  assign f_n = flags[3];
  assign f_z = flags[2];
  assign f_v = flags[0];

  always_comb begin
    en = 1'b0;
    case (cond)
      BR_U:    en = 1'b1;
      BR_E:    en = f_z;
      BR_NE:   en = !f_z;
      BR_G:    en = !f_z && (f_n == f_v);
      BR_GE:   en = (f_n == f_v);
      BR_L:    en = (f_n != f_v);
      BR_LE:   en = f_z || (f_n != f_v);
      BR_S:    en = f_n;
      BR_NS:   en = !f_n;
      default: en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vmicro16_alu_branch_unit.sv
// Bench for vmicro16_alu_branch_unit: directed plan vectors plus randomized traffic
// against an arithmetic reference model of the ALU, flags and branch conditions.
module tb_vmicro16_alu_branch_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [7:0]  cond;
  logic [3:0]  flags;
  logic        en;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_flags = 4'b0000;

  vmicro16_alu_branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .c     (c),
    .cond  (cond),
    .flags (flags),
    .en    (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference ALU computed with plain integer arithmetic.
  function automatic logic [15:0] model_c(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y);
    int ia, ib, sa, sb, sh, r, sd;
    ia = int'(x);
    ib = int'(y);
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    sh = ib % 16;
    case (o)
      5'h04, 5'h05: return y;
      5'h06: return 16'((ia + ib) % 65536);
      5'h07: return 16'((ia - ib + 65536) % 65536);
      5'h08: return x & y;
      5'h09: return x | y;
      5'h0A: return x ^ y;
      5'h0B: return 16'(65535 - ia);
      5'h0C: return 16'((ia * (1 << sh)) % 65536);
      5'h0D: return 16'(ia / (1 << sh));
      5'h0E: begin
        r = sa >>> sh;
        return 16'((r + 65536) % 65536);
      end
      5'h19: begin
        r  = (ia - ib + 65536) % 65536;
        sd = sa - sb;
        return {12'h000, r >= 32768, r == 0, (ia + ib) > 65535, (sd > 32767) || (sd < -32768)};
      end
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic model_en(input logic [3:0] f, input logic [7:0] cd);
    logic n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (cd)
      8'h00: return 1'b1;
      8'h01: return z;
      8'h02: return !z;
      8'h03: return !z && (n == v);
      8'h04: return n == v;
      8'h05: return n != v;
      8'h06: return z || (n != v);
      8'h07: return n;
      8'h08: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one cycle of inputs; check combinational outputs, then the registered result.
  task automatic step(input logic rs, input logic [4:0] o, input logic [15:0] x,
                      input logic [15:0] y, input logic [7:0] cd);
    logic [15:0] exp_c;
    reset = rs; op = o; a = x; b = y; cond = cd;
    exp_c = model_c(o, x, y);
    #1;
    check("c", c, exp_c);
    check("en_pre", 16'(en), 16'(model_en(exp_flags, cd)));
    @(posedge clk);
    if (rs) exp_flags = 4'b0000;
    else if (o == 5'h19) exp_flags = exp_c[3:0];
    #1;
    check("flags", 16'(flags), 16'(exp_flags));
    check("en_post", 16'(en), 16'(model_en(exp_flags, cd)));
  endtask

  task automatic probe(input string tag, input logic [7:0] cd, input logic exp);
    cond = cd;
    #1;
    check(tag, 16'(en), 16'(exp));
  endtask

  task automatic expect_c(input string tag, input logic [4:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] exp);
    op = o; a = x; b = y;
    #1;
    check(tag, c, exp);
  endtask

  logic [4:0] op_pool [14] = '{5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                               5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h19, 5'h19, 5'h1F};

  initial begin
    reset = 1'b1; op = 5'h00; a = 16'h0; b = 16'h0; cond = 8'h00;

    step(1'b1, 5'h00, 16'h0000, 16'h0000, 8'h00);
    step(1'b0, 5'h00, 16'h0000, 16'h0000, 8'h00);
    check("rst_flags", 16'(flags), 16'h0000);
    probe("rst_U", 8'h00, 1'b1);
    probe("rst_E", 8'h01, 1'b0);

    expect_c("cmp00_c", 5'h19, 16'h0000, 16'h0000, 16'h0004);
    step(1'b0, 5'h19, 16'h0000, 16'h0000, 8'h01);
    check("cmp00_flags", 16'(flags), 16'h0004);
    op = 5'h00;
    probe("cmp00_E", 8'h01, 1'b1);
    probe("cmp00_NE", 8'h02, 1'b0);
    probe("cmp00_U", 8'h00, 1'b1);

    expect_c("cmpAB_c", 5'h19, 16'h000A, 16'h000B, 16'h0008);
    step(1'b0, 5'h19, 16'h000A, 16'h000B, 8'h00);
    op = 5'h00;
    probe("cmpAB_U", 8'h00, 1'b1);
    probe("cmpAB_E", 8'h01, 1'b0);
    probe("cmpAB_NE", 8'h02, 1'b1);
    probe("cmpAB_L", 8'h05, 1'b1);
    probe("cmpAB_G", 8'h03, 1'b0);
    probe("cmpAB_LE", 8'h06, 1'b1);
    probe("cmpAB_S", 8'h07, 1'b1);

    step(1'b0, 5'h19, 16'h000B, 16'h000A, 8'h00);
    check("cmpBA_flags", 16'(flags), 16'h0000);
    op = 5'h00;
    probe("cmpBA_G", 8'h03, 1'b1);
    probe("cmpBA_GE", 8'h04, 1'b1);
    probe("cmpBA_L", 8'h05, 1'b0);
    probe("cmpBA_E", 8'h01, 1'b0);
    probe("cmpBA_NS", 8'h08, 1'b1);

    expect_c("cmpV_c", 5'h19, 16'h8000, 16'h0001, 16'h0001);
    step(1'b0, 5'h19, 16'h8000, 16'h0001, 8'h04);
    op = 5'h00;
    probe("cmpV_GE", 8'h04, 1'b0);
    probe("cmpV_L", 8'h05, 1'b1);
    step(1'b0, 5'h06, 16'h0001, 16'hFFFF, 8'h05);
    check("add_wrap_c", c, 16'h0000);
    check("add_keeps_flags", 16'(flags), 16'h0001);
    expect_c("cmpC_c", 5'h19, 16'hFFFF, 16'h0001, 16'h000A);

    // Reset wins over a simultaneous CMP.
    step(1'b0, 5'h19, 16'hFFFF, 16'h0001, 8'h07);
    step(1'b1, 5'h19, 16'h0000, 16'h0000, 8'h01);
    check("rst_vs_cmp", 16'(flags), 16'h0000);
    reset = 1'b0;

    expect_c("sw_add", 5'h06, 16'hF0F0, 16'h0004, 16'hF0F4);
    expect_c("sw_sub", 5'h07, 16'hF0F0, 16'h0004, 16'hF0EC);
    expect_c("sw_and", 5'h08, 16'hF0F0, 16'h0004, 16'h0000);
    expect_c("sw_or",  5'h09, 16'hF0F0, 16'h0004, 16'hF0F4);
    expect_c("sw_xor", 5'h0A, 16'hF0F0, 16'h0004, 16'hF0F4);
    expect_c("sw_not", 5'h0B, 16'hF0F0, 16'h0004, 16'h0F0F);
    expect_c("sw_lsl", 5'h0C, 16'hF0F0, 16'h0004, 16'h0F00);
    expect_c("sw_lsr", 5'h0D, 16'hF0F0, 16'h0004, 16'h0F0F);
    expect_c("sw_asr", 5'h0E, 16'hF0F0, 16'h0004, 16'hFF0F);
    expect_c("sw_mov", 5'h04, 16'hF0F0, 16'h0004, 16'h0004);
    expect_c("sw_bad", 5'h1F, 16'hF0F0, 16'h0004, 16'h0000);
    probe("cond_FF", 8'hFF, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] cd;
      cd = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      step($urandom_range(0, 24) == 0, op_pool[$urandom_range(0, 13)],
           16'($urandom), 16'($urandom), cd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
